// File: rtl/knn_topk_engine_if.sv
// knn_topk_engine_if: candidate stream (valid/ready with distance, index and last flag)
interface knn_topk_engine_if #(
  parameter int DIST_W = 16,
  parameter int IDX_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic [IDX_W-1:0]  in_idx;
  logic              in_last;
  modport master(output in_valid, in_dist, in_idx, in_last, input in_ready);
  modport slave(input in_valid, in_dist, in_idx, in_last, output in_ready);
endinterface

// File: rtl/knn_topk_engine.sv
// knn_topk_engine: sorted top-K buffer, pruning threshold and running K-th mean (KNN_DUP_FILTER_EN drops duplicate idx)
module knn_topk_engine #(
  parameter int K          = 8,
  parameter int DIST_W     = 16,
  parameter int IDX_W      = 16,
  parameter int MEAN_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     query_start,
  knn_topk_engine_if.slave         s,
  output logic [DIST_W-1:0]        threshold,
  output logic [K*DIST_W-1:0]      knn_dist,
  output logic [K*IDX_W-1:0]       knn_idx,
  output logic [$clog2(K+1)-1:0]   knn_count,
  output logic [DIST_W-1:0]        running_mean,
  output logic                     mean_valid,
  output logic                     query_done
);
  localparam int CW = $clog2(K+1);
  localparam logic [CW-1:0] KC = CW'(K);
  localparam logic [DIST_W-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [DIST_W-1:0] dist_q [K];
  logic [DIST_W-1:0] dist_d [K];
  logic [IDX_W-1:0] idx_q [K];
  logic [IDX_W-1:0] idx_d [K];
  logic [CW-1:0] count_q, count_d;
  logic [DIST_W-1:0] mean_q, mean_d;
  logic mean_valid_q, mean_valid_d, query_done_q, query_done_d;
  logic [K-1:0] le, at_p;
  logic full, acc, ins;
  logic signed [DIST_W:0] diff, step;
  assign full = count_q == KC;
  assign s.in_ready = state_q == RUN;
  assign acc = s.in_valid && s.in_ready && !query_start;
  assign diff = $signed({1'b0, dist_q[K-1]}) - $signed({1'b0, mean_q});
  assign step = diff >>> MEAN_SHIFT;
  assign threshold = full ? dist_q[K-1] : mean_valid_q ? mean_q : ONES;
  always_comb begin
    for (int i = 0; i < K; i++) begin
      le[i] = CW'(i) < count_q && dist_q[i] <= s.in_dist;
      at_p[i] = !le[i] && (i == 0 || le[i > 0 ? i - 1 : 0]);
    end
  end
`ifdef KNN_DUP_FILTER_EN
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < K; i++) dup = dup | (CW'(i) < count_q && idx_q[i] == s.in_idx);
  end
  assign ins = acc && (!full || s.in_dist < dist_q[K-1]) && !dup;
`else
  assign ins = acc && (!full || s.in_dist < dist_q[K-1]);
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dist_d = dist_q;
    idx_d = idx_q;
    mean_d = mean_q;
    mean_valid_d = mean_valid_q;
    query_done_d = state_q == FINISH;
    if (state_q == FINISH && full) begin
      mean_valid_d = 1'b1;
      mean_d = mean_valid_q ? DIST_W'({1'b0, mean_q} + step) : dist_q[K-1];
    end
    if (query_start) begin
      state_d = RUN;
      count_d = '0;
      for (int i = 0; i < K; i++) begin
        dist_d[i] = ONES;
        idx_d[i] = '0;
      end
    end else begin
      state_d = state_q == RUN ? (acc && s.in_last ? FINISH : RUN) : IDLE;
      if (ins) begin
        count_d = full ? count_q : count_q + CW'(1);
        for (int i = 0; i < K; i++) begin
          dist_d[i] = le[i] ? dist_q[i] : at_p[i] ? s.in_dist : dist_q[i > 0 ? i - 1 : 0];
          idx_d[i] = le[i] ? idx_q[i] : at_p[i] ? s.in_idx : idx_q[i > 0 ? i - 1 : 0];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mean_q <= '0;
      mean_valid_q <= 1'b0;
      query_done_q <= 1'b0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= ONES;
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mean_q <= mean_d;
      mean_valid_q <= mean_valid_d;
      query_done_q <= query_done_d;
      dist_q <= dist_d;
      idx_q <= idx_d;
    end
  end
  for (genvar g = 0; g < K; g++) begin : g_out
    assign knn_dist[g*DIST_W +: DIST_W] = dist_q[g];
    assign knn_idx[g*IDX_W +: IDX_W] = idx_q[g];
  end
  assign knn_count = count_q;
  assign running_mean = mean_q;
  assign mean_valid = mean_valid_q;
  assign query_done = query_done_q;
endmodule

// File: tb/tb_knn_topk_engine.sv
// tb_knn_topk_engine: directed and randomized checks of knn_topk_engine against a queue-based model
module tb_knn_topk_engine;
  localparam int K = 8, DW = 16, IW = 16, S = 3, CW = $clog2(K+1);
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic query_start = 1'b0;
  logic [DW-1:0] threshold, running_mean;
  logic [K*DW-1:0] knn_dist;
  logic [K*IW-1:0] knn_idx;
  logic [CW-1:0] knn_count;
  logic mean_valid, query_done;
  knn_topk_engine_if #(.DIST_W(DW), .IDX_W(IW)) s();
  knn_topk_engine #(.K(K), .DIST_W(DW), .IDX_W(IW), .MEAN_SHIFT(S)) dut (
    .clk(clk), .rst(rst), .query_start(query_start), .s(s),
    .threshold(threshold), .knn_dist(knn_dist), .knn_idx(knn_idx), .knn_count(knn_count),
    .running_mean(running_mean), .mean_valid(mean_valid), .query_done(query_done)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int md[$];
  int mi[$];
  int mean = 0;
  bit mv = 1'b0;
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask
  function automatic void m_clear();
    md.delete();
    mi.delete();
  endfunction
  function automatic void m_ins(int d, int ix);
    int p;
`ifdef KNN_DUP_FILTER_EN
    foreach (mi[j]) if (mi[j] == ix) return;
`endif
    if (md.size() == K && d >= md[K-1]) return;
    p = 0;
    foreach (md[j]) if (md[j] <= d) p++;
    md.insert(p, d);
    mi.insert(p, ix);
    if (md.size() > K) begin
      void'(md.pop_back());
      void'(mi.pop_back());
    end
  endfunction
  function automatic void m_finish();
    if (md.size() == K) begin
      mean = mv ? mean + ((md[K-1] - mean) >>> S) : md[K-1];
      mv = 1'b1;
    end
  endfunction
  function automatic int m_thr();
    return md.size() == K ? md[K-1] : mv ? mean : 65535;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(string tag);
    logic [K*DW-1:0] ed;
    logic [K*IW-1:0] ei, mask;
    for (int j = 0; j < K; j++) begin
      ed[j*DW +: DW] = j < md.size() ? DW'(md[j]) : '1;
      ei[j*IW +: IW] = j < md.size() ? IW'(mi[j]) : '0;
      mask[j*IW +: IW] = j < md.size() ? '1 : '0;
    end
    chk({tag, ".dist"}, knn_dist, ed);
    chk({tag, ".idx"}, knn_idx & mask, ei);
    chk({tag, ".count"}, knn_count, md.size());
    chk({tag, ".thr"}, threshold, m_thr());
    chk({tag, ".mean"}, running_mean, mean);
    chk({tag, ".mv"}, mean_valid, mv);
  endtask
  task automatic qs();
    query_start = 1'b1;
    tick();
    query_start = 1'b0;
    m_clear();
    chk("qs.ready", s.in_ready, 1);
    check_all("qs");
  endtask
  task automatic beat(int d, int ix, bit last);
    chk("beat.ready", s.in_ready, 1);
    s.in_valid = 1'b1;
    s.in_dist = DW'(d);
    s.in_idx = IW'(ix);
    s.in_last = last;
    tick();
    s.in_valid = 1'b0;
    s.in_last = 1'b0;
    m_ins(d, ix);
    check_all("beat");
  endtask
  task automatic finish_q(bit restart);
    chk("fin.ready", s.in_ready, 0);
    chk("fin.qd", query_done, 0);
    if (restart) begin
      query_start = 1'b1;
      tick();
      query_start = 1'b0;
      m_finish();
      m_clear();
      chk("fin_qs.ready", s.in_ready, 1);
      check_all("fin_qs");
    end else begin
      tick();
      m_finish();
      chk("done.qd", query_done, 1);
      chk("done.ready", s.in_ready, 0);
      check_all("done");
      tick();
      chk("after.qd", query_done, 0);
    end
  endtask
  initial begin
    bit in_run;
    s.in_valid = 1'b0;
    s.in_dist = '0;
    s.in_idx = '0;
    s.in_last = 1'b0;
    repeat (3) tick();
    check_all("reset");
    chk("reset.ready", s.in_ready, 0);
    chk("reset.qd", query_done, 0);
    rst = 1'b1;
    tick();
    s.in_valid = 1'b1;
    s.in_dist = 16'd1;
    s.in_idx = 16'd9;
    tick();
    s.in_valid = 1'b0;
    check_all("idle_ignore");
    qs();
    for (int i = 0; i < 8; i++) beat(80 - 10 * i, i, 1'b0);
    chk("thr80", threshold, 80);
    chk("sorted", knn_dist, {16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10});
    beat(80, 100, 1'b0);
    beat(5, 101, 1'b0);
    chk("thr70", threshold, 70);
    chk("slot0_5", knn_dist[15:0], 5);
    beat(65535, 102, 1'b1);
    finish_q(1'b0);
    rst = 1'b0;
    tick();
    m_clear();
    mean = 0;
    mv = 1'b0;
    check_all("reset_mid");
    rst = 1'b1;
    qs();
    for (int i = 0; i < 8; i++) beat(64, 10 + i, i == 7);
    finish_q(1'b0);
    chk("mean64", running_mean, 64);
    chk("mv1", mean_valid, 1);
    qs();
    for (int i = 0; i < 8; i++) beat(32, 20 + i, i == 7);
    finish_q(1'b0);
    chk("mean60", running_mean, 60);
    qs();
    for (int i = 0; i < 5; i++) begin
      beat($urandom_range(0, 500), i, i == 4);
      chk("thr_mean", threshold, 60);
    end
    finish_q(1'b0);
    chk("mean_keep", running_mean, 60);
    qs();
    for (int i = 0; i < 3; i++) beat($urandom_range(0, 500), i, 1'b0);
    s.in_valid = 1'b1;
    s.in_dist = 16'd7;
    s.in_idx = 16'd7;
    query_start = 1'b1;
    tick();
    s.in_valid = 1'b0;
    query_start = 1'b0;
    m_clear();
    chk("abort.count", knn_count, 0);
    chk("abort.ready", s.in_ready, 1);
    check_all("abort");
    beat(20, 3, 1'b0);
    beat(10, 3, 1'b0);
`ifdef KNN_DUP_FILTER_EN
    chk("dup.count", knn_count, 1);
    chk("dup.slot0", knn_dist[15:0], 20);
`else
    chk("dup.count", knn_count, 2);
    chk("dup.slot0", knn_dist[15:0], 10);
`endif
    beat(40, 1, 1'b1);
    finish_q(1'b1);
    in_run = 1'b1;
    for (int q = 0; q < 30; q++) begin
      int len;
      bit rs;
      if (!in_run) qs();
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
          check_all("gap");
        end
        beat($urandom_range(0, 300), $urandom_range(0, 15), b == len - 1);
      end
      rs = $urandom_range(0, 4) == 0;
      finish_q(rs);
      in_run = rs;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
